llc_direct_mapped: RTL and testbench
====================================

# llc_direct_mapped

Direct-mapped, write-back, write-allocate last-level cache sitting directly upstream of the cacheline adaptor. It serves 32-bit word requests from the CPU-side memory port and issues whole-line (256-bit) reads and writes to the adaptor. The adaptor converts each line transfer into four 64-bit memory bursts.

## Interface
Parameters:
- S_INDEX, 4, index width; number of sets is 2^S_INDEX.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset; asynchronous, active-low.
- mem_address  in  32  CPU byte address; must be held stable until mem_resp.
- mem_read  in  1  CPU read request; level, held until mem_resp.
- mem_write  in  1  CPU write request; level, held until mem_resp.
- mem_wmask  in  4  byte enables for writes; bit i covers mem_wdata[8i+7:8i].
- mem_wdata  in  32  write data.
- mem_rdata  out  32  read data; valid only while mem_resp=1, otherwise 0.
- mem_resp  out  1  one-cycle completion pulse for the current request.
- pmem_address  out  32  line address to the adaptor; low 5 bits always 0.
- pmem_read  out  1  line read request; held until pmem_resp.
- pmem_write  out  1  line write request; held until pmem_resp.
- pmem_wdata  out  256  line being written back.
- pmem_rdata  in  256  fill line; valid when pmem_resp=1.
- pmem_resp  in  1  line transfer complete.

## Operation
- Address split:
  - offset = [4:0]; word select = [4:2].
  - index = [4+S_INDEX:5].
  - tag = [31:5+S_INDEX].
- Word k of a line occupies bits [32k+31:32k]. Line bits [63:0] correspond to adaptor burst 0.
- Per-set storage: data line (256), tag, valid, dirty.
  - valid and dirty are reset to 0.
  - data and tag have no reset.
- hit = valid[index] && tag[index] == address tag.
- FSM states: IDLE, COMPARE, WRITEBACK, FILL.
- IDLE:
  - mem_read or mem_write asserted -> COMPARE.
  - Otherwise stay in IDLE.
- COMPARE:
  - No request present -> IDLE, no mem_resp.
  - Hit -> assert mem_resp, next state IDLE.
    - Read: mem_rdata = selected word.
    - Write: merge mem_wdata bytes where mem_wmask=1 into the selected word; set dirty.
  - Miss and dirty -> WRITEBACK.
  - Miss and clean -> FILL.
- WRITEBACK:
  - pmem_write=1, pmem_address={stored tag, index, 5'b0}, pmem_wdata=stored line.
  - On pmem_resp: clear dirty, next state FILL.
- FILL:
  - pmem_read=1, pmem_address={request tag, index, 5'b0}.
  - On pmem_resp: store pmem_rdata and tag, set valid=1, dirty=0, next state COMPARE. The request then hits in COMPARE.
- Simultaneous mem_read and mem_write: treated as a write (protocol violation, but behaviour is defined).
- pmem_read and pmem_write are never both 1.
- A request dropped during WRITEBACK or FILL: the line transfer still completes, then COMPARE sees no request and returns to IDLE without mem_resp.

## Timing
- Reset values:
  - State = IDLE.
  - mem_resp=0, mem_rdata=0.
  - pmem_read=0, pmem_write=0, pmem_address=0, pmem_wdata=0.
  - All valid/dirty bits = 0.
- Reset asserted in any state, including mid-transfer: outputs drop combinationally to reset values on that cycle, and the in-flight transfer is abandoned.
- All outputs are Moore outputs of the FSM state plus storage. None depends combinationally on pmem_resp.
- Hit latency: request first seen in cycle N (IDLE), mem_resp in cycle N+1.
- Clean miss:
  - pmem_read rises in cycle N+2.
  - pmem_resp arrives in cycle M; COMPARE runs in M+1 with mem_resp=1.
- Dirty miss:
  - pmem_write rises in cycle N+2.
  - After pmem_resp in cycle W, pmem_read rises in cycle W+1; the rest follows the clean-miss timing.
- Write-hit update and dirty set take effect at the clock edge ending the mem_resp cycle.
- mem_resp is exactly one cycle per request. The CPU may present the next request in the cycle after mem_resp, and it is seen in IDLE.

## Test plan
- Reset; read 0x0000_0104. Expect:
  - pmem_read with pmem_address=0x0000_0100 and no pmem_write.
  - Memory returns a line whose word k = 0xA000_000k.
  - mem_rdata=0xA000_0001 with a single-cycle mem_resp one cycle after pmem_resp.
- Read 0x0000_0108 after the previous fill. Expect a hit: mem_resp on the 2nd cycle, mem_rdata=0xA000_0002, no pmem activity.
- Write 0x0000_0100 with wdata=0xDEAD_BEEF, wmask=4'b0011. Expect a hit with mem_resp on the 2nd cycle; a following read of 0x0000_0100 returns 0xA000_BEEF.
- Read 0x0000_0300 (index 8, tag differs) after the dirty write. Expect, in order:
  - pmem_write with pmem_address=0x0000_0100 and pmem_wdata[31:0]=0xA000_BEEF.
  - pmem_read with pmem_address=0x0000_0300.
  - mem_resp with the filled word 0.
- Assert reset_n=0 mid-FILL (pmem_read=1). Expect pmem_read=0 in the same cycle and state IDLE. A subsequent read of 0x0000_0104 misses again (valid cleared).
- Assert mem_read and mem_write together to 0x0000_0104 on a hit, with wmask=4'hF and wdata=0x1234_5678. Expect the request to be handled as a write; a following read returns 0x1234_5678.

Source files
------------

// File: rtl/llc_direct_mapped.sv
// rtl/llc_direct_mapped.sv - direct-mapped write-back write-allocate last-level cache
// Serves 32-bit CPU word requests and moves whole 256-bit lines to and from the cacheline adaptor.
module llc_direct_mapped #(
  parameter int S_INDEX = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_wmask,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);
  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_COMPARE   = 2'd1;
  localparam logic [1:0] ST_WRITEBACK = 2'd2;
  localparam logic [1:0] ST_FILL      = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SETS-1:0]  valid_q, valid_d;
  logic [SETS-1:0]  dirty_q, dirty_d;
  logic [255:0]     data_q [SETS];
  logic [TAG_W-1:0] tag_q  [SETS];

  logic [S_INDEX-1:0] idx;
  logic [TAG_W-1:0]   req_tag;
  logic [7:0]         wbase;
  logic               req, hit, resp_hit;
  logic [255:0]       cur_line, merged_line;
  logic [31:0]        cur_word;
  logic               unused_ok;

  assign idx       = mem_address[4+S_INDEX:5];
  assign req_tag   = mem_address[31:5+S_INDEX];
  assign wbase     = {mem_address[4:2], 5'b0};
  assign unused_ok = &{1'b0, mem_address[1:0]};

  assign req      = mem_read | mem_write;
  assign cur_line = data_q[idx];
  assign cur_word = cur_line[wbase +: 32];
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);
  assign resp_hit = (state_q == ST_COMPARE) && req && hit;

  // A simultaneous read+write is handled as a write: the merge and dirty set key off mem_write alone.
  always_comb begin
    merged_line = cur_line;
    for (int b = 0; b < 4; b++) begin
      if (mem_wmask[b]) merged_line[wbase + 8'(8*b) +: 8] = mem_wdata[8*b +: 8];
    end
  end

  assign mem_resp     = resp_hit;
  assign mem_rdata    = resp_hit ? cur_word : 32'd0;
  assign pmem_write   = (state_q == ST_WRITEBACK);
  assign pmem_read    = (state_q == ST_FILL);
  assign pmem_wdata   = pmem_write ? cur_line : 256'd0;

  always_comb begin
    pmem_address = 32'd0;
    if (state_q == ST_WRITEBACK) pmem_address = {tag_q[idx], idx, 5'b0};
    else if (state_q == ST_FILL) pmem_address = {req_tag, idx, 5'b0};
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    dirty_d = dirty_q;
    case (state_q)
      ST_IDLE: if (req) state_d = ST_COMPARE;
      ST_COMPARE: begin
        if (!req || hit) begin
          state_d = ST_IDLE;
          if (req && mem_write) dirty_d[idx] = 1'b1;
        end else if (dirty_q[idx]) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WRITEBACK: begin
        if (pmem_resp) begin
          dirty_d[idx] = 1'b0;
          state_d      = ST_FILL;
        end
      end
      ST_FILL: begin
        if (pmem_resp) begin
          valid_d[idx] = 1'b1;
          dirty_d[idx] = 1'b0;
          state_d      = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Line and tag storage carry no reset; writes are gated by FSM state, which reset holds in IDLE.
  always_ff @(posedge clk) begin
    if (state_q == ST_FILL && pmem_resp) begin
      data_q[idx] <= pmem_rdata;
      tag_q[idx]  <= req_tag;
    end else if (resp_hit && mem_write) begin
      data_q[idx] <= merged_line;
    end
  end
endmodule

// File: tb/tb_llc_direct_mapped.sv
// tb/tb_llc_direct_mapped.sv - directed self-checking bench for llc_direct_mapped
module tb_llc_direct_mapped;
  logic         clk = 1'b0;
  logic         reset_n;
  logic [31:0]  mem_address;
  logic         mem_read, mem_write;
  logic [3:0]   mem_wmask;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  int tests_run = 0;
  int tests_failed = 0;

  int           r_cyc, r_nwb, r_nrd, r_wb_cyc, r_rd_cyc;
  logic         r_got, r_resp_after, r_both;
  logic [31:0]  r_rdata, r_wb_addr, r_rd_addr;
  logic [255:0] r_wb_data;

  always #5 clk = ~clk;

  llc_direct_mapped #(.S_INDEX(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic logic [255:0] make_line(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base | 32'(k);
    return l;
  endfunction

  // Drives one CPU request from an IDLE cycle and plays the adaptor (pmem_resp on the 2nd cycle of each transfer).
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input logic [255:0] fill);
    int wait_cnt;
    wait_cnt = 0;
    r_got = 0; r_cyc = -1; r_rdata = 0; r_resp_after = 0; r_both = 0;
    r_nwb = 0; r_nrd = 0; r_wb_cyc = -1; r_rd_cyc = -1;
    r_wb_addr = 0; r_rd_addr = 0; r_wb_data = 0;
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_wdata = wdata; mem_wmask = wmask; pmem_rdata = fill;
    for (int i = 0; i < 40 && !r_got; i++) begin
      if (mem_resp) begin
        r_got = 1; r_cyc = i; r_rdata = mem_rdata;
      end else begin
        if (pmem_read && pmem_write) r_both = 1;
        if (pmem_resp) begin pmem_resp = 0; wait_cnt = 0; end
        if (pmem_read || pmem_write) begin
          if (wait_cnt == 0) begin
            if (pmem_write) begin
              r_nwb++; r_wb_cyc = i; r_wb_addr = pmem_address; r_wb_data = pmem_wdata;
            end else begin
              r_nrd++; r_rd_cyc = i; r_rd_addr = pmem_address;
            end
          end
          wait_cnt++;
          if (wait_cnt == 2) pmem_resp = 1;
        end
        @(posedge clk); #1;
      end
    end
    if (r_got) begin @(posedge clk); #1; end
    mem_read = 0; mem_write = 0; pmem_resp = 0;
    r_resp_after = mem_resp;
  endtask

  task automatic test_reset;
    reset_n = 1; mem_read = 0; mem_write = 0; mem_address = 0;
    mem_wdata = 0; mem_wmask = 0; pmem_rdata = 0; pmem_resp = 0;
    #2 reset_n = 0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (mem_resp !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_resp: got %b expected 0", mem_resp); end
    tests_run++; if (mem_rdata !== 32'd0) begin tests_failed++; $display("FAIL reset_mem_rdata: got %h expected 0", mem_rdata); end
    tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_read: got %b expected 0", pmem_read); end
    tests_run++; if (pmem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_pmem_write: got %b expected 0", pmem_write); end
    tests_run++; if (pmem_address !== 32'd0) begin tests_failed++; $display("FAIL reset_pmem_address: got %h expected 0", pmem_address); end
    tests_run++; if (pmem_wdata !== 256'd0) begin tests_failed++; $display("FAIL reset_pmem_wdata: got %h expected 0", pmem_wdata); end
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_miss;
    access(1, 0, 32'h0000_0104, 32'h0, 4'h0, make_line(32'hA000_0000));
    tests_run++; if (r_got !== 1'b1) begin tests_failed++; $display("FAIL miss_resp_seen: got %b expected 1", r_got); end
    tests_run++; if (r_rdata !== 32'hA000_0001) begin tests_failed++; $display("FAIL miss_rdata: got %h expected a0000001", r_rdata); end
    tests_run++; if (r_cyc !== 4) begin tests_failed++; $display("FAIL miss_resp_cycle: got %0d expected 4", r_cyc); end
    tests_run++; if (r_nrd !== 1) begin tests_failed++; $display("FAIL miss_read_count: got %0d expected 1", r_nrd); end
    tests_run++; if (r_rd_cyc !== 2) begin tests_failed++; $display("FAIL miss_read_cycle: got %0d expected 2", r_rd_cyc); end
    tests_run++; if (r_rd_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL miss_read_addr: got %h expected 00000100", r_rd_addr); end
    tests_run++; if (r_nwb !== 0) begin tests_failed++; $display("FAIL miss_no_writeback: got %0d expected 0", r_nwb); end
    tests_run++; if (r_resp_after !== 1'b0) begin tests_failed++; $display("FAIL miss_resp_one_cycle: got %b expected 0", r_resp_after); end
  endtask

  task automatic test_read_hit;
    access(1, 0, 32'h0000_0108, 32'h0, 4'h0, 256'd0);
    tests_run++; if (r_rdata !== 32'hA000_0002) begin tests_failed++; $display("FAIL hit_rdata: got %h expected a0000002", r_rdata); end
    tests_run++; if (r_cyc !== 1) begin tests_failed++; $display("FAIL hit_resp_cycle: got %0d expected 1", r_cyc); end
    tests_run++; if (r_nrd + r_nwb !== 0) begin tests_failed++; $display("FAIL hit_no_pmem: got %0d expected 0", r_nrd + r_nwb); end
  endtask

  task automatic test_write_hit;
    access(0, 1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011, 256'd0);
    tests_run++; if (r_cyc !== 1) begin tests_failed++; $display("FAIL write_hit_cycle: got %0d expected 1", r_cyc); end
    tests_run++; if (r_nrd + r_nwb !== 0) begin tests_failed++; $display("FAIL write_hit_no_pmem: got %0d expected 0", r_nrd + r_nwb); end
    access(1, 0, 32'h0000_0100, 32'h0, 4'h0, 256'd0);
    tests_run++; if (r_rdata !== 32'hA000_BEEF) begin tests_failed++; $display("FAIL write_merge_rdata: got %h expected a000beef", r_rdata); end
    tests_run++; if (r_cyc !== 1) begin tests_failed++; $display("FAIL write_readback_cycle: got %0d expected 1", r_cyc); end
  endtask

  task automatic test_dirty_miss;
    logic [255:0] exp_line;
    exp_line = make_line(32'hA000_0000);
    exp_line[31:0] = 32'hA000_BEEF;
    access(1, 0, 32'h0000_0300, 32'h0, 4'h0, make_line(32'hB000_0000));
    tests_run++; if (r_nwb !== 1) begin tests_failed++; $display("FAIL dirty_wb_count: got %0d expected 1", r_nwb); end
    tests_run++; if (r_wb_cyc !== 2) begin tests_failed++; $display("FAIL dirty_wb_cycle: got %0d expected 2", r_wb_cyc); end
    tests_run++; if (r_wb_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL dirty_wb_addr: got %h expected 00000100", r_wb_addr); end
    tests_run++; if (r_wb_data !== exp_line) begin tests_failed++; $display("FAIL dirty_wb_data: got %h expected %h", r_wb_data, exp_line); end
    tests_run++; if (r_nrd !== 1) begin tests_failed++; $display("FAIL dirty_fill_count: got %0d expected 1", r_nrd); end
    tests_run++; if (r_rd_cyc !== 4) begin tests_failed++; $display("FAIL dirty_fill_cycle: got %0d expected 4", r_rd_cyc); end
    tests_run++; if (r_rd_addr !== 32'h0000_0300) begin tests_failed++; $display("FAIL dirty_fill_addr: got %h expected 00000300", r_rd_addr); end
    tests_run++; if (r_rdata !== 32'hB000_0000) begin tests_failed++; $display("FAIL dirty_rdata: got %h expected b0000000", r_rdata); end
    tests_run++; if (r_cyc !== 6) begin tests_failed++; $display("FAIL dirty_resp_cycle: got %0d expected 6", r_cyc); end
    tests_run++; if (r_both !== 1'b0) begin tests_failed++; $display("FAIL dirty_rd_wr_exclusive: got %b expected 0", r_both); end
  endtask

  task automatic test_reset_mid_fill;
    logic found;
    found = 0;
    mem_address = 32'h0000_0104; mem_read = 1; mem_write = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (pmem_read) found = 1;
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL rst_fill_reached: got %b expected 1", found); end
    reset_n = 0;
    #1;
    tests_run++; if (pmem_read !== 1'b0) begin tests_failed++; $display("FAIL rst_pmem_read_drop: got %b expected 0", pmem_read); end
    tests_run++; if (pmem_address !== 32'd0) begin tests_failed++; $display("FAIL rst_pmem_addr_drop: got %h expected 0", pmem_address); end
    mem_read = 0;
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;
    tests_run++; if (pmem_read !== 1'b0 || mem_resp !== 1'b0) begin tests_failed++; $display("FAIL rst_idle_outputs: got %b%b expected 00", pmem_read, mem_resp); end
    access(1, 0, 32'h0000_0104, 32'h0, 4'h0, make_line(32'hA000_0000));
    tests_run++; if (r_nrd !== 1) begin tests_failed++; $display("FAIL rst_remiss_count: got %0d expected 1", r_nrd); end
    tests_run++; if (r_rd_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL rst_remiss_addr: got %h expected 00000100", r_rd_addr); end
    tests_run++; if (r_rdata !== 32'hA000_0001) begin tests_failed++; $display("FAIL rst_remiss_rdata: got %h expected a0000001", r_rdata); end
    tests_run++; if (r_cyc !== 4) begin tests_failed++; $display("FAIL rst_remiss_cycle: got %0d expected 4", r_cyc); end
  endtask

  task automatic test_read_write_together;
    access(1, 1, 32'h0000_0104, 32'h1234_5678, 4'hF, 256'd0);
    tests_run++; if (r_cyc !== 1) begin tests_failed++; $display("FAIL rw_hit_cycle: got %0d expected 1", r_cyc); end
    tests_run++; if (r_nrd + r_nwb !== 0) begin tests_failed++; $display("FAIL rw_no_pmem: got %0d expected 0", r_nrd + r_nwb); end
    access(1, 0, 32'h0000_0104, 32'h0, 4'h0, 256'd0);
    tests_run++; if (r_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL rw_readback: got %h expected 12345678", r_rdata); end
    access(1, 0, 32'h0000_0108, 32'h0, 4'h0, 256'd0);
    tests_run++; if (r_rdata !== 32'hA000_0002) begin tests_failed++; $display("FAIL rw_neighbour_word: got %h expected a0000002", r_rdata); end
    tests_run++; if (r_cyc !== 1) begin tests_failed++; $display("FAIL back_to_back_cycle: got %0d expected 1", r_cyc); end
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_miss();
    test_reset_mid_fill();
    test_read_write_together();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
